axi4_sram_mb: RTL
=================

AXI4_SRAM_MB -- requirements
Module: axi4_sram_mb

Interface
REQ-001 Parameter DATA_W, default 32: AXI data width, in bits; power of two, 32..128.
REQ-002 Parameter ADDR_W, default 32: AXI byte-address width.
REQ-003 Parameter ID_W, default 4: AXI ID width.
REQ-004 Parameter WORD_DEPTH, default 512: total DATA_W-bit words; power of two.
REQ-005 Parameter NUM_BANKS, default 4: word-interleaved banks; power of two; divides WORD_DEPTH.
REQ-006 clk_i  in  1  single clock; all logic on rising edge.
REQ-007 rst_n_i  in  1  reset, synchronous and active-low.
REQ-008 awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/8/3/2/1  write-address channel; awready out 1.
REQ-009 wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write-data channel; wready out 1.
REQ-010 bid/bresp/bvalid  out  ID_W/2/1  write-response channel; bready in 1.
REQ-011 arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/8/3/2/1  read-address channel; arready out 1.
REQ-012 rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read-data channel; rready in 1.

Function
REQ-013 One transaction at a time; FSM states IDLE, WR_DATA, WR_RESP, RD_DATA.
REQ-014 IDLE: awready/arready high only in IDLE. If both valids are high, alternate priority: last granted write -> read wins, and vice versa. After reset, write wins first.
REQ-015 AW accepted -> latch id/addr/len/size/burst, go to WR_DATA. AR accepted -> same, go to RD_DATA.
REQ-016 WR_DATA: wready high. Each beat with wvalid writes the bank word in that same edge, with byte enables from wstrb. The beat after len beats moves to WR_RESP; wlast is ignored for counting.
REQ-017 WR_RESP: bvalid high, bid is the latched id. Hold until bready, then go to IDLE. No AW/AR is accepted while in WR_RESP.
REQ-018 RD_DATA: bank read latency is 1 cycle. Throughput is 1 beat per cycle while rready is high. rdata/rid/rresp/rlast are stable while rvalid && !rready. rlast is set on beat len; the handshake on that beat goes to IDLE.
REQ-019 Beat address FIXED: constant.
REQ-020 Beat address INCR: addr += 2**size, no 4KB wrap check.
REQ-021 Beat address WRAP: wrap at aligned boundary of (len+1)*2**size bytes. Legal len for WRAP is 1, 3, 7, 15.
REQ-022 Narrow transfers (size < log2(DATA_W/8)) are supported.
REQ-023 Write lane mask = wstrb AND size/offset lane mask.
REQ-024 Read returns the full word.
REQ-025 Word index = addr[ADDR_W-1:log2(DATA_W/8)].
REQ-026 Bank = word index mod NUM_BANKS; row = word index / NUM_BANKS.
REQ-027 Only the addressed bank is enabled each cycle.
REQ-028 SLVERR on the whole burst: word index >= WORD_DEPTH on any beat, illegal WRAP len, size > log2(DATA_W/8), or burst==2'b11.
REQ-029 On an SLVERR write, all writes are suppressed; on an SLVERR read, every beat gives rdata=0 and rresp=SLVERR. Beat count and handshakes are unchanged.
REQ-030 Otherwise OKAY.
REQ-031 awlen=0 and arlen=0 are single beats and need no special casing.

Reset
REQ-032 rst_n_i low at any edge: FSM -> IDLE.
REQ-033 Reset values: awready=arready=wready=bvalid=rvalid=rlast=0; bid, rid, bresp, rresp, rdata = 0.
REQ-034 Reset priority pointer = write.
REQ-035 Reset mid-burst aborts it, with no response issued.
REQ-036 Memory contents are not cleared by reset.

Structure
REQ-037 Package axi4_sram_mb_pkg holds burst_t (FIXED/INCR/WRAP), resp_t (OKAY/SLVERR), state_t, and the address-step/wrap function.
REQ-038 Sub-module sram_bank: 1RW, byte-enabled, registered read, depth WORD_DEPTH/NUM_BANKS; instantiated NUM_BANKS times via generate.
REQ-039 The wrapper keeps the existing axi4_if slave modport usable, through a thin adapter outside this module.

Verification
REQ-040 INCR write awaddr=0x0, len=7, size=2, data 0..7, full strobes; then INCR read same -> data 0..7, rlast on beat 7, rresp=OKAY, bresp=OKAY, reads back-to-back with rready=1.
REQ-041 WRAP read araddr=0x18, len=3, size=2 -> addresses 0x18, 0x1C, 0x10, 0x14.
REQ-042 Write 0xAABBCCDD to 0x40, then wstrb=4'b0010 data 0x00001100 -> read 0xAABB11DD.
REQ-043 awaddr=WORD_DEPTH*4-4, INCR len=1 -> both beats accepted, bresp=SLVERR, word at WORD_DEPTH*4-4 unchanged.
REQ-044 Simultaneous awvalid/arvalid after reset -> write granted first, read next. Repeat -> read first.
REQ-045 Assert rst_n_i low for 1 cycle at read beat 3 of len=7 -> rvalid=0 next cycle, IDLE. Prior memory contents intact on re-read.

Source files
------------

// File: rtl/axi4_sram_mb_pkg.sv
// Shared types and burst address arithmetic for the banked AXI4 SRAM slave.
// Pure declarations; no state.
package axi4_sram_mb_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_DATA
  } state_t;

  // Address of the beat following addr; computed at 64 bits so callers of any
  // ADDR_W below 64 can zero-extend in and truncate out.
  function automatic logic [63:0] beat_next_addr(input logic [63:0] addr,
                                                 input logic [7:0]  len,
                                                 input logic [2:0]  size,
                                                 input burst_t      burst);
    logic [63:0] step;
    logic [63:0] span;
    logic [63:0] nxt;
    step = 64'd1 << size;
    span = (64'(len) + 64'd1) << size;
    nxt  = addr + step;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~(span - 64'd1)) | (nxt & (span - 64'd1));
      default:     nxt = addr + step;
    endcase
    return nxt;
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_sram_mb_bank.sv
// Single-port byte-enabled SRAM bank with a registered read port (1-cycle latency).
// The read register holds its value while en_i is low.
module sram_bank
  import axi4_sram_mb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/axi4_sram_mb.sv
// AXI4 slave over word-interleaved SRAM banks, one burst at a time.
// Reads stream at 1 beat/cycle after a 2-cycle start; rready low freezes the R channel.
module axi4_sram_mb
  import axi4_sram_mb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int WORD_DEPTH = 512,
  parameter int NUM_BANKS  = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [7:0]          awlen_i,
  input  logic [2:0]          awsize_i,
  input  logic [1:0]          awburst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wlast_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [ID_W-1:0]     bid_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ID_W-1:0]     arid_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [7:0]          arlen_i,
  input  logic [2:0]          arsize_i,
  input  logic [1:0]          arburst_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [ID_W-1:0]     rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic                rvalid_o,
  input  logic                rready_i
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int BANK_SH = $clog2(NUM_BANKS);
  localparam int BANK_W  = (NUM_BANKS > 1) ? BANK_SH : 1;
  localparam int ROWS    = WORD_DEPTH / NUM_BANKS;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t              state_q;
  logic                rdy_en_q;
  logic                prio_rd_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [8:0]          beat_q;
  logic [8:0]          out_cnt_q;
  logic                rd_pend_q;
  logic [BANK_W-1:0]   pend_bank_q;

  logic                aw_hs, ar_hs;
  logic [63:0]         acc_addr64, acc_last64, acc_span64;
  logic [7:0]          acc_len;
  logic [2:0]          acc_size;
  logic [1:0]          acc_burst;
  logic [ID_W-1:0]     acc_id;
  logic                acc_err;

  logic [63:0]         cur_addr64, nxt_full;
  logic [ADDR_W-1:0]   addr_d;
  logic [63-ADDR_W:0]  unused_nxt_hi;
  logic                unused_wlast;

  logic [BANK_W-1:0]   cur_bank;
  logic [ROW_W-1:0]    cur_row;
  logic [STRB_W-1:0]   lane_mask;
  logic                wr_fire, rd_issue, rd_load, out_free, bank_go;
  logic [DATA_W-1:0]   bank_rdat [NUM_BANKS];

  // Readies are only offered in IDLE and only to the channel the arbiter would pick,
  // so a losing valid never sees a handshake.
  assign awready_o = rdy_en_q && (!arvalid_i || !prio_rd_q);
  assign arready_o = rdy_en_q && (!awvalid_i || prio_rd_q);
  assign aw_hs     = awvalid_i && awready_o;
  assign ar_hs     = arvalid_i && arready_o;
  assign unused_wlast = wlast_i;

  always_comb begin
    acc_addr64 = '0;
    acc_addr64[ADDR_W-1:0] = aw_hs ? awaddr_i : araddr_i;
    acc_len    = aw_hs ? awlen_i   : arlen_i;
    acc_size   = aw_hs ? awsize_i  : arsize_i;
    acc_burst  = aw_hs ? awburst_i : arburst_i;
    acc_id     = aw_hs ? awid_i    : arid_i;
    acc_span64 = (64'(acc_len) + 64'd1) << acc_size;
    case (acc_burst)
      BURST_INCR: acc_last64 = acc_addr64 + (64'(acc_len) << acc_size);
      BURST_WRAP: acc_last64 = (acc_addr64 & ~(acc_span64 - 64'd1)) + acc_span64 - 64'd1;
      default:    acc_last64 = acc_addr64;
    endcase
    // The highest byte touched decides range errors for the whole burst up front.
    acc_err = (int'(acc_size) > BYTE_SH) || (acc_burst == 2'b11) ||
              ((acc_burst == BURST_WRAP) && !wrap_len_ok(acc_len)) ||
              ((acc_last64 >> BYTE_SH) >= 64'(WORD_DEPTH));
  end

  always_comb begin
    int lo, hi, stp;
    cur_addr64 = '0;
    cur_addr64[ADDR_W-1:0] = addr_q;
    nxt_full = beat_next_addr(cur_addr64, len_q, size_q, burst_t'(burst_q));
    {unused_nxt_hi, addr_d} = nxt_full;
    cur_bank = (NUM_BANKS > 1) ? addr_q[BYTE_SH +: BANK_W] : '0;
    cur_row  = addr_q[BYTE_SH + BANK_SH +: ROW_W];
    stp = 1 << size_q;
    lo  = int'(addr_q[BYTE_SH-1:0]);
    hi  = (lo & ~(stp - 1)) + stp;
    for (int i = 0; i < STRB_W; i++) lane_mask[i] = (i >= lo) && (i < hi);
  end

  assign out_free = !rvalid_o || rready_i;
  assign wr_fire  = (state_q == S_WR_DATA) && wvalid_i;
  // A new bank read is issued only when the previous one can drain this cycle;
  // otherwise the bank's read register holds the pending word.
  assign rd_issue = (state_q == S_RD_DATA) && (beat_q <= {1'b0, len_q}) &&
                    (!rd_pend_q || out_free);
  assign rd_load  = (state_q == S_RD_DATA) && rd_pend_q && out_free;
  assign bank_go  = (wr_fire || rd_issue) && !err_q;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sram_bank #(.DATA_W(DATA_W), .DEPTH(ROWS)) u_bank (
      .clk_i   (clk_i),
      .en_i    (bank_go && (cur_bank == BANK_W'(g))),
      .we_i    (wr_fire),
      .be_i    (wstrb_i & lane_mask),
      .addr_i  (cur_row),
      .wdata_i (wdata_i),
      .rdata_o (bank_rdat[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      rdy_en_q    <= 1'b0;
      prio_rd_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      beat_q      <= '0;
      out_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      pend_bank_q <= '0;
      wready_o    <= 1'b0;
      bvalid_o    <= 1'b0;
      bid_o       <= '0;
      bresp_o     <= RESP_OKAY;
      rvalid_o    <= 1'b0;
      rlast_o     <= 1'b0;
      rid_o       <= '0;
      rresp_o     <= RESP_OKAY;
      rdata_o     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_en_q <= 1'b1;
          if (aw_hs || ar_hs) begin
            id_q      <= acc_id;
            addr_q    <= acc_addr64[ADDR_W-1:0];
            len_q     <= acc_len;
            size_q    <= acc_size;
            burst_q   <= acc_burst;
            err_q     <= acc_err;
            beat_q    <= '0;
            out_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            rdy_en_q  <= 1'b0;
            // Priority only flips when both channels actually contended.
            if (awvalid_i && arvalid_i) prio_rd_q <= aw_hs;
          end
          if (aw_hs) begin
            state_q  <= S_WR_DATA;
            wready_o <= 1'b1;
          end else if (ar_hs) begin
            state_q <= S_RD_DATA;
            rid_o   <= acc_id;
          end
        end
        S_WR_DATA: begin
          if (wvalid_i) begin
            addr_q <= addr_d;
            beat_q <= beat_q + 9'd1;
            if (beat_q == {1'b0, len_q}) begin
              state_q  <= S_WR_RESP;
              wready_o <= 1'b0;
              bvalid_o <= 1'b1;
              bid_o    <= id_q;
              bresp_o  <= err_q ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_WR_RESP: begin
          if (bready_i) begin
            bvalid_o <= 1'b0;
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (rd_issue) begin
            addr_q      <= addr_d;
            beat_q      <= beat_q + 9'd1;
            pend_bank_q <= cur_bank;
            rd_pend_q   <= 1'b1;
          end else if (rd_load) begin
            rd_pend_q <= 1'b0;
          end
          if (rd_load) begin
            rvalid_o  <= 1'b1;
            rdata_o   <= err_q ? '0 : bank_rdat[pend_bank_q];
            rresp_o   <= err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_o   <= (out_cnt_q == {1'b0, len_q});
            out_cnt_q <= out_cnt_q + 9'd1;
          end else if (rvalid_o && rready_i) begin
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
          end
          if (rvalid_o && rready_i && rlast_o) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
